xillybus_mem_responder: RTL and testbench
=========================================

// Module: xillybus_mem_responder
// PURPOSE
//  User-side responder for the addressable 8-bit Xillybus stream pair (mem_8): write stream, read stream, address/addr_update.
//  Holds a DEPTH x 8 register bank written and read back by the host through the core; each stream auto-increments its own pointer.
//  Second read-only port exposes the bank to application logic; a write-event strobe reports each committed host write.
//  Sits beside the Xillybus core on bus_clk; connects directly to the core's user_*_mem_8_* signals.
// PARAMETERS
//  ADDR_W   5    address width; must match the core's user_mem_8_addr width
//  DEPTH    32   bank entries; must equal 2**ADDR_W
// PORTS
//  bus_clk               in   1       sole clock (core user clock)
//  trn_reset_n           in   1       reset: synchronous, active-low
//  quiesce               in   1       core quiescent; stream strobes ignored while high
//  user_mem_8_addr       in   ADDR_W  start address from host seek
//  user_mem_8_addr_update in  1       one-cycle strobe; load both pointers from user_mem_8_addr
//  user_w_mem_8_wren     in   1       write strobe
//  user_w_mem_8_data     in   8       write data
//  user_w_mem_8_full     out  1       always 0 (bank never back-pressures)
//  user_w_mem_8_open     in   1       host write file open
//  user_r_mem_8_rden     in   1       read strobe
//  user_r_mem_8_data     out  8       read data; valid the cycle after rden
//  user_r_mem_8_empty    out  1       no data available (EOF mode only, see CONFIGURATION)
//  user_r_mem_8_eof      out  1       end-of-file (EOF mode only)
//  user_r_mem_8_open     in   1       host read file open
//  app_raddr             in   ADDR_W  application read address
//  app_rdata             out  8       mem[app_raddr], registered, 1-cycle latency
//  wr_evt                out  1       one-cycle pulse per committed host write
//  wr_evt_addr           out  ADDR_W  address written on that pulse
// BEHAVIOUR
//  - Reset (trn_reset_n=0 at clock edge): all DEPTH entries <= 0; wr_ptr=rd_ptr=0; user_r_mem_8_data=0; app_rdata=0;
//    wr_evt=0; wr_evt_addr=0; empty=0; eof=0; full=0; eof_flag cleared. Reset mid-stream discards pending pointer state.
//  - addr_update=1: wr_ptr, rd_ptr <= user_mem_8_addr; eof_flag cleared. Wins over increment in the same cycle.
//  - Write: wren=1 and quiesce=0 -> mem[wa] <= data, where wa = addr_update ? user_mem_8_addr : wr_ptr; wr_ptr <= wa+1 mod DEPTH;
//    wr_evt=1, wr_evt_addr=wa on the next cycle.
//  - Read: rden=1, quiesce=0, empty=0 -> user_r_mem_8_data <= mem[ra] (ra selected like wa); rd_ptr <= ra+1 mod DEPTH.
//    Data holds until the next accepted rden. rden while empty=1 is ignored (no pointer move, data held).
//  - Same-address write and read in one cycle: read returns the OLD value (read-before-write). Same rule applies to app_rdata.
//  - quiesce=1: wren/rden ignored; addr_update still honoured; outputs hold.
//  - user_r_mem_8_open falling: eof_flag cleared; pointers kept. Open signals have no other effect.
//  - Pointer wrap: DEPTH-1 +1 -> 0 (ADDR_W-bit natural overflow).
// CONFIGURATION
//  Macro XILLYBUS_MEM_EOF_EN:
//   defined   - accepting rden at ra=DEPTH-1 sets eof_flag next cycle; empty=eof=eof_flag; rd_ptr stays at 0 after wrap;
//               cleared by addr_update, read-close, or reset. Writes unaffected (wrap freely).
//   undefined - empty=0, eof=0 constant; rd_ptr wraps silently; eof_flag logic absent.
// STRUCTURE
//  Package xillybus_mem_pkg: ADDR_W/DEPTH defaults, mem_addr_t typedef, RESET_BYTE constant (8'h00).
//  Sub-module xillybus_mem_ptr (load, inc, wrap, next-value output), instantiated twice: write and read pointers.
//  Bank is a flop array (DEPTH small), cleared by reset.
// TESTING
//  1. Reset, addr=3 + addr_update, write 8'hA1,8'hB2 -> mem[3]=A1, mem[4]=B2; wr_evt pulses with addr 3 then 4.
//  2. addr_update to 3, rden x2 -> data=A1 the cycle after the first rden, B2 after the second; empty=0.
//  3. addr_update to 31, write 8'h55,8'h66 -> mem[31]=55, mem[0]=66 (wrap); app_raddr=0 -> app_rdata=66 one cycle later.
//  4. EOF_EN: addr_update to 30, rden x2 -> eof=empty=1 after the second; third rden ignored, data held; addr_update clears.
//  5. Write 8'h77 and read at addr 5 in the same cycle -> read data = prior mem[5]; a subsequent read returns 77.
//  6. quiesce=1 with wren/rden -> no mem change, no pointer move, no wr_evt; reset mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/xillybus_mem_pkg.sv
// Shared defaults and types for the Xillybus mem_8 register-bank responder.
package xillybus_mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] mem_addr_t;

  localparam logic [7:0] RESET_BYTE = 8'h00;
endpackage

// File: rtl/xillybus_mem_ptr.sv
// Auto-incrementing stream pointer with host-seek load; cur is the address used this cycle.
module xillybus_mem_ptr #(
  parameter int ADDR_W = xillybus_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cur,
  output logic [ADDR_W-1:0] nxt
);
  logic [ADDR_W-1:0] ptr_q;

  // A seek in the same cycle as an access makes the access use the seek address.
  assign cur = load ? load_val : ptr_q;
  assign nxt = inc ? cur + ADDR_W'(1) : cur;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= nxt;
  end
endmodule

// File: rtl/xillybus_mem_responder.sv
// Xillybus mem_8 user-side responder: DEPTH x 8 bank, host write/read streams, app read port.
// Optional EOF on read wrap is enabled by defining XILLYBUS_MEM_EOF_EN.
module xillybus_mem_responder
  import xillybus_mem_pkg::*;
#(
  parameter int ADDR_W = xillybus_mem_pkg::ADDR_W,
  parameter int DEPTH  = xillybus_mem_pkg::DEPTH
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  input  logic              quiesce,
  input  logic [ADDR_W-1:0] user_mem_8_addr,
  input  logic              user_mem_8_addr_update,
  input  logic              user_w_mem_8_wren,
  input  logic [7:0]        user_w_mem_8_data,
  output logic              user_w_mem_8_full,
  input  logic              user_w_mem_8_open,
  input  logic              user_r_mem_8_rden,
  output logic [7:0]        user_r_mem_8_data,
  output logic              user_r_mem_8_empty,
  output logic              user_r_mem_8_eof,
  input  logic              user_r_mem_8_open,
  input  logic [ADDR_W-1:0] app_raddr,
  output logic [7:0]        app_rdata,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] wr_evt_addr
);
  logic [7:0]        mem [DEPTH];
  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] wa, ra, wr_nxt, rd_nxt;

  assign user_w_mem_8_full = 1'b0;
  assign wr_acc = user_w_mem_8_wren & ~quiesce;
  assign rd_acc = user_r_mem_8_rden & ~quiesce & ~user_r_mem_8_empty;

  xillybus_mem_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk(bus_clk), .rst_n(trn_reset_n), .load(user_mem_8_addr_update),
    .load_val(user_mem_8_addr), .inc(wr_acc), .cur(wa), .nxt(wr_nxt)
  );

  xillybus_mem_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk(bus_clk), .rst_n(trn_reset_n), .load(user_mem_8_addr_update),
    .load_val(user_mem_8_addr), .inc(rd_acc), .cur(ra), .nxt(rd_nxt)
  );

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_BYTE;
    end else if (wr_acc) begin
      mem[wa] <= user_w_mem_8_data;
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      user_r_mem_8_data <= RESET_BYTE;
      app_rdata         <= RESET_BYTE;
      wr_evt            <= 1'b0;
      wr_evt_addr       <= '0;
    end else begin
      if (rd_acc) user_r_mem_8_data <= mem[ra];
      app_rdata <= mem[app_raddr];
      wr_evt    <= wr_acc;
      if (wr_acc) wr_evt_addr <= wa;
    end
  end

`ifdef XILLYBUS_MEM_EOF_EN
  logic eof_flag, r_open_q;

  // Hitting the last entry ends the file until the host seeks or closes the read side.
  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      eof_flag <= 1'b0;
      r_open_q <= 1'b0;
    end else begin
      r_open_q <= user_r_mem_8_open;
      if (rd_acc && ra == ADDR_W'(DEPTH - 1))
        eof_flag <= 1'b1;
      else if (user_mem_8_addr_update || (r_open_q && !user_r_mem_8_open))
        eof_flag <= 1'b0;
    end
  end

  assign user_r_mem_8_empty = eof_flag;
  assign user_r_mem_8_eof   = eof_flag;

  logic unused_inputs;
  assign unused_inputs = ^{user_w_mem_8_open, wr_nxt, rd_nxt};
`else
  assign user_r_mem_8_empty = 1'b0;
  assign user_r_mem_8_eof   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{user_w_mem_8_open, user_r_mem_8_open, wr_nxt, rd_nxt};
`endif
endmodule

// File: tb/tb_xillybus_mem_responder.sv
// Randomized bench for xillybus_mem_responder against a behavioural bank model; honours XILLYBUS_MEM_EOF_EN.
module tb_xillybus_mem_responder;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
`ifdef XILLYBUS_MEM_EOF_EN
  localparam bit EOF_EN = 1'b1;
`else
  localparam bit EOF_EN = 1'b0;
`endif

  logic              bus_clk = 1'b0;
  logic              trn_reset_n;
  logic              quiesce;
  logic [ADDR_W-1:0] user_mem_8_addr;
  logic              user_mem_8_addr_update;
  logic              user_w_mem_8_wren;
  logic [7:0]        user_w_mem_8_data;
  logic              user_w_mem_8_full;
  logic              user_w_mem_8_open;
  logic              user_r_mem_8_rden;
  logic [7:0]        user_r_mem_8_data;
  logic              user_r_mem_8_empty;
  logic              user_r_mem_8_eof;
  logic              user_r_mem_8_open;
  logic [ADDR_W-1:0] app_raddr;
  logic [7:0]        app_rdata;
  logic              wr_evt;
  logic [ADDR_W-1:0] wr_evt_addr;

  xillybus_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .quiesce(quiesce),
    .user_mem_8_addr(user_mem_8_addr), .user_mem_8_addr_update(user_mem_8_addr_update),
    .user_w_mem_8_wren(user_w_mem_8_wren), .user_w_mem_8_data(user_w_mem_8_data),
    .user_w_mem_8_full(user_w_mem_8_full), .user_w_mem_8_open(user_w_mem_8_open),
    .user_r_mem_8_rden(user_r_mem_8_rden), .user_r_mem_8_data(user_r_mem_8_data),
    .user_r_mem_8_empty(user_r_mem_8_empty), .user_r_mem_8_eof(user_r_mem_8_eof),
    .user_r_mem_8_open(user_r_mem_8_open), .app_raddr(app_raddr), .app_rdata(app_rdata),
    .wr_evt(wr_evt), .wr_evt_addr(wr_evt_addr)
  );

  // ---------------- clock / reset ----------------
  always #5 bus_clk = ~bus_clk;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_wp, m_rp;
  bit         m_eof, m_open_prev;
  logic [7:0] m_rdata, m_app;
  bit         m_evt;
  int         m_evt_addr;

  always @(posedge bus_clk) begin : model
    int  wa, ra;
    bit  wacc, racc;
    if (!trn_reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_wp = 0; m_rp = 0; m_eof = 0; m_open_prev = 0;
      m_rdata = 8'h00; m_app = 8'h00; m_evt = 0; m_evt_addr = 0;
    end else begin
      wa   = user_mem_8_addr_update ? int'(user_mem_8_addr) : m_wp;
      ra   = user_mem_8_addr_update ? int'(user_mem_8_addr) : m_rp;
      wacc = user_w_mem_8_wren && !quiesce;
      racc = user_r_mem_8_rden && !quiesce && !(EOF_EN && m_eof);
      if (racc) m_rdata = m_mem[ra];
      m_app = m_mem[app_raddr];
      m_evt = wacc;
      if (wacc) begin
        m_evt_addr = wa;
        m_mem[wa]  = user_w_mem_8_data;
      end
      m_wp = wacc ? (wa + 1) % DEPTH : wa;
      m_rp = racc ? (ra + 1) % DEPTH : ra;
      if (EOF_EN) begin
        if (racc && ra == DEPTH - 1) m_eof = 1;
        else if (user_mem_8_addr_update || (m_open_prev && !user_r_mem_8_open)) m_eof = 0;
      end
      m_open_prev = user_r_mem_8_open;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge bus_clk) begin
    if (check_en) begin
      n_vec++;
      chk("r_data",      32'(user_r_mem_8_data), 32'(m_rdata));
      chk("app_rdata",   32'(app_rdata), 32'(m_app));
      chk("wr_evt",      32'(wr_evt), 32'(m_evt));
      chk("wr_evt_addr", 32'(wr_evt_addr), 32'(m_evt_addr));
      chk("full",        32'(user_w_mem_8_full), 32'(0));
      chk("empty",       32'(user_r_mem_8_empty), 32'(EOF_EN && m_eof));
      chk("eof",         32'(user_r_mem_8_eof), 32'(EOF_EN && m_eof));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge bus_clk);
    @(negedge bus_clk);
  endtask

  task automatic idle();
    user_mem_8_addr_update = 0;
    user_w_mem_8_wren      = 0;
    user_r_mem_8_rden      = 0;
    quiesce                = 0;
  endtask

  task automatic seek_wr(input bit upd, input int addr, input bit wren, input logic [7:0] d, input bit rden);
    idle();
    user_mem_8_addr_update = upd;
    user_mem_8_addr        = ADDR_W'(addr);
    user_w_mem_8_wren      = wren;
    user_w_mem_8_data      = d;
    user_r_mem_8_rden      = rden;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    trn_reset_n = 0; idle();
    user_mem_8_addr = '0; user_w_mem_8_data = '0; app_raddr = '0;
    user_w_mem_8_open = 1; user_r_mem_8_open = 1;
    check_en = 1;
    step(); step();
    chk("reset_rdata", 32'(user_r_mem_8_data), 32'h0);
    chk("reset_evt", 32'(wr_evt), 32'h0);
    trn_reset_n = 1;

    // host writes A1, B2 from address 3
    seek_wr(1, 3, 1, 8'hA1, 0);
    chk("t1_evt0", {wr_evt, 27'(wr_evt_addr)}, {1'b1, 27'd3});
    seek_wr(0, 0, 1, 8'hB2, 0);
    chk("t1_evt1", {wr_evt, 27'(wr_evt_addr)}, {1'b1, 27'd4});
    idle(); app_raddr = 3; step();
    chk("t1_app3", 32'(app_rdata), 32'hA1);
    app_raddr = 4; step();
    chk("t1_app4", 32'(app_rdata), 32'hB2);

    // host reads back
    seek_wr(1, 3, 0, 8'h00, 1);
    chk("t2_rd0", 32'(user_r_mem_8_data), 32'hA1);
    seek_wr(0, 0, 0, 8'h00, 1);
    chk("t2_rd1", 32'(user_r_mem_8_data), 32'hB2);
    chk("t2_empty", 32'(user_r_mem_8_empty), 32'h0);

    // write wrap at the top of the bank
    seek_wr(1, 31, 1, 8'h55, 0);
    seek_wr(0, 0, 1, 8'h66, 0);
    idle(); app_raddr = 0; step();
    chk("t3_app0", 32'(app_rdata), 32'h66);

    // read wrap: EOF or silent wrap
    seek_wr(1, 30, 0, 8'h00, 1);
    seek_wr(0, 0, 0, 8'h00, 1);
    chk("t4_rd31", 32'(user_r_mem_8_data), 32'h55);
    chk("t4_eof", 32'(user_r_mem_8_eof), 32'(EOF_EN));
    seek_wr(0, 0, 0, 8'h00, 1);
    chk("t4_rd_after", 32'(user_r_mem_8_data), EOF_EN ? 32'h55 : 32'h66);
    seek_wr(1, 0, 0, 8'h00, 0);
    chk("t4_cleared", 32'(user_r_mem_8_eof), 32'h0);

    // same-address write and read
    seek_wr(1, 5, 1, 8'h11, 0);
    app_raddr = 5;
    seek_wr(1, 5, 1, 8'h77, 1);
    chk("t5_rbw", 32'(user_r_mem_8_data), 32'h11);
    chk("t5_app_rbw", 32'(app_rdata), 32'h11);
    seek_wr(1, 5, 0, 8'h00, 1);
    chk("t5_new", 32'(user_r_mem_8_data), 32'h77);
    chk("t5_app_new", 32'(app_rdata), 32'h77);

    // quiesce blocks stream strobes
    for (int i = 0; i < 3; i++) begin
      idle(); quiesce = 1; user_w_mem_8_wren = 1; user_r_mem_8_rden = 1;
      user_w_mem_8_data = 8'hEE; step();
      chk("t6_q_evt", 32'(wr_evt), 32'h0);
      chk("t6_q_data", 32'(user_r_mem_8_data), 32'h77);
    end
    seek_wr(0, 0, 1, 8'h3C, 0);
    user_w_mem_8_data = 8'h4D; trn_reset_n = 0; step();
    chk("t6_rst_data", 32'(user_r_mem_8_data), 32'h0);
    chk("t6_rst_evt", {wr_evt, 27'(wr_evt_addr)}, 32'h0);
    chk("t6_rst_app", 32'(app_rdata), 32'h0);
    trn_reset_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      quiesce                = ($urandom_range(0, 9) == 0);
      user_mem_8_addr_update = ($urandom_range(0, 15) == 0);
      user_mem_8_addr        = ADDR_W'($urandom_range(0, DEPTH - 1));
      user_w_mem_8_wren      = $urandom_range(0, 1);
      user_w_mem_8_data      = 8'($urandom_range(0, 255));
      user_r_mem_8_rden      = $urandom_range(0, 1);
      if (!quiesce) app_raddr = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 49) == 0) user_r_mem_8_open = ~user_r_mem_8_open;
      if ($urandom_range(0, 49) == 0) user_w_mem_8_open = ~user_w_mem_8_open;
      trn_reset_n = ($urandom_range(0, 499) != 0);
      step();
    end
    trn_reset_n = 1; idle(); step();

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
